// File: rtl/prog_mem.sv
// prog_mem: instruction RAM with an AXI-Stream program loader that packs
// narrow beats into words, halts the CPU while loading, and fetches at 1 or 2 cycles.
module prog_mem #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LOAD_WIDTH = 32,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LOAD_WIDTH-1:0] load_TDATA,
   input  logic                  load_TVALID,
   output logic                  load_TREADY,
   input  logic                  load_TLAST,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  cpu_halt,
   output logic [ADDR_WIDTH:0]   prog_len,
   output logic                  load_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned RATIO = DATA_WIDTH / LOAD_WIDTH;
   localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned PW    = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   logic [PW-1:0]         r_wr_ptr;
   logic [BW-1:0]         r_beat;
   logic [DATA_WIDTH-1:0] r_asm;
   logic                  r_tready;
   logic                  r_halt;
   logic [PW-1:0]         r_prog_len;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_acc;
   logic [PW-1:0]         w_ptr;
   logic [PW-1:0]         w_ptr_inc;
   logic [BW-1:0]         w_beat;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_complete;
   logic                  w_at_end;
   logic                  w_we;

   // A load starting in RUN always begins at address 0, beat 0.
   assign w_acc      = load_TVALID & r_tready;
   assign w_ptr      = (r_state == RUN) ? '0 : r_wr_ptr;
   assign w_beat     = (r_state == RUN) ? '0 : r_beat;
   assign w_ptr_inc  = w_ptr + PW'(1);
   assign w_word     = r_asm | (DATA_WIDTH'(load_TDATA) << (LOAD_WIDTH * 32'(w_beat)));
   assign w_complete = (w_beat == BW'(RATIO - 1)) | load_TLAST;
   assign w_at_end   = (w_ptr == PW'(DEPTH - 1));
   assign w_we       = w_acc & (r_state != DRAIN) & w_complete;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_ptr[ADDR_WIDTH-1:0]] <= w_word;
      end
   end

   // Loader FSM; the assembler is kept zero between words so a TLAST
   // mid-word leaves the unfilled upper slices cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_wr_ptr   <= '0;
         r_beat     <= '0;
         r_asm      <= '0;
         r_tready   <= 1'b0;
         r_halt     <= 1'b0;
         r_prog_len <= '0;
         r_err      <= 1'b0;
      end else begin
         r_tready <= 1'b1;
         if (w_acc) begin
            if (r_state == DRAIN) begin
               r_err <= 1'b1;
               if (load_TLAST) begin
                  r_state    <= RUN;
                  r_halt     <= 1'b0;
                  r_prog_len <= r_wr_ptr;
                  r_beat     <= '0;
               end
            end else begin
               if (r_state == RUN) begin
                  r_err <= 1'b0;
               end
               if (w_complete) begin
                  r_wr_ptr <= w_ptr_inc;
                  r_beat   <= '0;
                  r_asm    <= '0;
                  if (load_TLAST) begin
                     r_state    <= RUN;
                     r_halt     <= 1'b0;
                     r_prog_len <= w_ptr_inc;
                  end else if (w_at_end) begin
                     r_state <= DRAIN;
                     r_halt  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= LOAD;
                     r_halt  <= 1'b1;
                  end
               end else begin
                  r_wr_ptr <= w_ptr;
                  r_beat   <= w_beat + BW'(1);
                  r_asm    <= w_word;
                  r_state  <= LOAD;
                  r_halt   <= 1'b1;
               end
            end
         end
      end
   end

   // Read-first fetch path, optionally with an extra output stage.
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] r_rd_q;
         logic                  r_rd_v;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_rd_q     <= '0;
               r_rd_v     <= 1'b0;
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_v     <= rd_en;
               r_rd_valid <= r_rd_v;
               if (rd_en) begin
                  r_rd_q <= r_mem[rd_addr];
               end
               if (r_rd_v) begin
                  r_rd_data <= r_rd_q;
               end
            end
         end
      end else begin : g_no_reg
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= rd_en;
               if (rd_en) begin
                  r_rd_data <= r_mem[rd_addr];
               end
            end
         end
      end
   endgenerate

   assign load_TREADY = r_tready;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign cpu_halt    = r_halt;
   assign prog_len    = r_prog_len;
   assign load_err    = r_err;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: two instances (latency 1 and 2) share stimulus
// and are checked against a word-level program/memory model.
module tb_prog_mem;

   localparam int AW    = 2;
   localparam int DW    = 64;
   localparam int LW    = 32;
   localparam int RATIO = DW / LW;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [LW-1:0] tdata = '0;
   logic          tvalid = 1'b0;
   logic          tlast = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_en = 1'b0;

   logic          tready0, tready1, rdv0, rdv1, halt0, halt1, err0, err1;
   logic [DW-1:0] rdd0, rdd1;
   logic [AW:0]   len0, len1;

   prog_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_WIDTH(LW), .OUT_REG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .load_TDATA(tdata), .load_TVALID(tvalid),
      .load_TREADY(tready0), .load_TLAST(tlast), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rdd0), .rd_valid(rdv0), .cpu_halt(halt0), .prog_len(len0), .load_err(err0));

   prog_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_WIDTH(LW), .OUT_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load_TDATA(tdata), .load_TVALID(tvalid),
      .load_TREADY(tready1), .load_TLAST(tlast), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rdd1), .rd_valid(rdv1), .cpu_halt(halt1), .prog_len(len1), .load_err(err1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [63:0] d;
      logic [31:0] due;
   } rd_exp_t;

   rd_exp_t q0[$];
   rd_exp_t q1[$];
   rd_exp_t e0, e1;

   // Reference model: memory image plus per-program beat bookkeeping.
   logic [63:0] mem_m [DEPTH];
   int          bi = 0;
   logic [63:0] cur_word = '0;
   logic [AW:0] exp_len = '0;
   logic        exp_err = 1'b0;
   logic        exp_halt = 1'b0;
   logic        exp_tready = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic check_status();
      chk("tready",   64'({tready1, tready0}), 64'({2{exp_tready}}));
      chk("cpu_halt", 64'({halt1, halt0}),     64'({2{exp_halt}}));
      chk("load_err", 64'({err1, err0}),       64'({2{exp_err}}));
      chk("prog_len0", 64'(len0), 64'(exp_len));
      chk("prog_len1", 64'(len1), 64'(exp_len));
   endtask

   // Beat bi of the program belongs to word bi/RATIO, slice bi%RATIO.
   task automatic model_beat(input logic [31:0] d, input logic last);
      int wi;
      int sl;
      wi = bi / RATIO;
      sl = bi % RATIO;
      if (bi == 0) exp_err = 1'b0;
      cur_word = cur_word | (64'(d) << (32 * sl));
      if (sl == RATIO - 1 || last) begin
         if (wi < DEPTH) mem_m[wi] = cur_word;
         cur_word = '0;
      end
      if (last) begin
         exp_len  = (wi + 1 > DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(wi + 1);
         exp_err  = (wi + 1 > DEPTH);
         exp_halt = 1'b0;
         bi       = 0;
      end else begin
         exp_halt = 1'b1;
         if (wi >= DEPTH || (wi == DEPTH - 1 && sl == RATIO - 1)) exp_err = 1'b1;
         bi++;
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic last,
                       input logic re, input logic [AW-1:0] ra);
      @(negedge clk);
      check_status();
      if (re) begin
         q0.push_back('{d: mem_m[ra], due: 32'(cyc + 1)});
         q1.push_back('{d: mem_m[ra], due: 32'(cyc + 2)});
      end
      tvalid  = v;
      tdata   = d;
      tlast   = last;
      rd_en   = re;
      rd_addr = ra;
      if (v) model_beat(d, last);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_status();
      rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
      bi = 0; cur_word = '0; exp_len = '0; exp_err = 1'b0; exp_halt = 1'b0; exp_tready = 1'b0;
      @(negedge clk);
      check_status();
      chk("rd_data0_rst", rdd0, 64'h0);
      chk("rd_data1_rst", rdd1, 64'h0);
      rst_n = 1'b1;
      exp_tready = 1'b1;
   endtask

   // Monitors: pop an expectation whenever a fetch result appears.
   always @(negedge clk) begin
      if (rdv0 === 1'b1) begin
         if (q0.size() == 0) chk("rd_valid0_spurious", 64'd1, 64'd0);
         else begin
            e0 = q0.pop_front();
            chk("rd_data0", rdd0, e0.d);
            chk("rd_lat0", 64'(cyc), 64'(e0.due));
         end
      end else if (q0.size() != 0 && q0[0].due <= 32'(cyc)) begin
         chk("rd_valid0_missing", 64'd0, 64'd1);
         void'(q0.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rdv1 === 1'b1) begin
         if (q1.size() == 0) chk("rd_valid1_spurious", 64'd1, 64'd0);
         else begin
            e1 = q1.pop_front();
            chk("rd_data1", rdd1, e1.d);
            chk("rd_lat1", 64'(cyc), 64'(e1.due));
         end
      end else if (q1.size() != 0 && q1[0].due <= 32'(cyc)) begin
         chk("rd_valid1_missing", 64'd0, 64'd1);
         void'(q1.pop_front());
      end
   end

   initial begin
      int          nb;
      int          i;
      logic        v;
      logic        re;
      logic [AW-1:0] ra;
      for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;

      do_reset();

      // Two-beat program, then fetch it back.
      step(1'b1, 32'h11111111, 1'b0, 1'b0, '0);
      step(1'b1, 32'h22222222, 1'b1, 1'b0, '0);
      step(1'b0, '0, 1'b0, 1'b1, 2'd0);
      idle(3);

      // Three beats: second word is a zero-padded partial.
      step(1'b1, 32'hAAAA0001, 1'b0, 1'b0, '0);
      step(1'b1, 32'hAAAA0002, 1'b0, 1'b0, '0);
      step(1'b1, 32'h00000033, 1'b1, 1'b0, '0);
      idle(1);

      // Back-to-back fetches 0,1,0.
      step(1'b0, '0, 1'b0, 1'b1, 2'd0);
      step(1'b0, '0, 1'b0, 1'b1, 2'd1);
      step(1'b0, '0, 1'b0, 1'b1, 2'd0);
      idle(3);

      // Ten-word program into a four-word memory.
      for (int k = 0; k < 20; k++) step(1'b1, 32'h1000 + 32'(k), (k == 19), 1'b0, '0);
      idle(1);
      for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b0, 1'b1, AW'(k));
      idle(3);

      // Read and write of address 0 in the same cycle.
      step(1'b1, 32'hBEEF0001, 1'b0, 1'b1, 2'd0);
      step(1'b1, 32'hBEEF0002, 1'b1, 1'b1, 2'd0);
      step(1'b0, '0, 1'b0, 1'b1, 2'd0);
      idle(3);

      // Reset in the middle of the second word.
      step(1'b1, 32'hC0DE0001, 1'b0, 1'b0, '0);
      step(1'b1, 32'hC0DE0002, 1'b0, 1'b0, '0);
      step(1'b1, 32'hC0DE0003, 1'b0, 1'b0, '0);
      do_reset();
      for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b0, 1'b1, AW'(k));
      step(1'b1, 32'h5A5A0001, 1'b0, 1'b0, '0);
      step(1'b1, 32'h5A5A0002, 1'b1, 1'b0, '0);
      step(1'b0, '0, 1'b0, 1'b1, 2'd0);
      step(1'b0, '0, 1'b0, 1'b1, 2'd1);
      idle(3);

      // Random programs with gaps and concurrent fetches.
      for (int p = 0; p < 40; p++) begin
         nb = $urandom_range(1, 12);
         i  = 0;
         while (i < nb) begin
            v  = ($urandom_range(0, 3) != 0);
            re = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, DEPTH - 1));
            step(v, $urandom, v && (i == nb - 1), re, ra);
            if (v) i++;
         end
         nb = $urandom_range(0, 2);
         for (int k = 0; k < nb; k++) begin
            re = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, DEPTH - 1));
            step(1'b0, '0, 1'b0, re, ra);
         end
      end

      idle(4);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
